// File: rtl/y86_pkg.sv
// Purpose: shared Y86-64 constants (icodes, status codes) and the memory-access FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_pkg;

    // Instruction codes that touch data memory
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Y86 status codes
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    // Memory access unit states
    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_REQ  = 2'd1,
        MAU_DONE = 2'd2
    } mau_state_t;

endpackage

// File: rtl/mem_op_decode.sv
// Purpose: decode the memory operation of an instruction and bounds-check its address.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   icode            instruction code
//   valE/valA/valP   ALU result, register A / old %rsp, next PC
//   is_mem           instruction accesses data memory
//   is_write         access is a store
//   addr, wdata      byte address and store data
//   addr_ok          access fits inside the legal data space (always 1 for non-memory ops)
module mem_op_decode
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 4096
) (
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] valE,
    input  logic [ADDR_W-1:0] valA,
    input  logic [ADDR_W-1:0] valP,
    output logic              is_mem,
    output logic              is_write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              addr_ok
);

    // One extra bit so that an access wrapping past the top of the
    // address space lands above the limit instead of back near zero.
    localparam logic [ADDR_W:0] ACC_BYTES = (ADDR_W+1)'(DATA_W / 8);
    localparam logic [ADDR_W:0] LIMIT     = (ADDR_W+1)'(MEM_BYTES);

    logic [ADDR_W:0] end_addr;

    always_comb begin
        is_mem   = 1'b0;
        is_write = 1'b0;
        addr     = '0;
        wdata    = '0;
        case (icode)
            I_RMMOVQ, I_PUSHQ: begin
                is_mem   = 1'b1;
                is_write = 1'b1;
                addr     = valE;
                wdata    = DATA_W'(valA);
            end
            I_CALL: begin
                is_mem   = 1'b1;
                is_write = 1'b1;
                addr     = valE;
                wdata    = DATA_W'(valP);
            end
            I_MRMOVQ: begin
                is_mem = 1'b1;
                addr   = valE;
            end
            // ret and popq read from the old stack pointer, not the updated one
            I_RET, I_POPQ: begin
                is_mem = 1'b1;
                addr   = valA;
            end
            default: begin
                is_mem = 1'b0;
            end
        endcase
    end

    assign end_addr = {1'b0, addr} + ACC_BYTES;
    assign addr_ok  = !is_mem || (end_addr <= LIMIT);

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: multi-cycle Y86-64 data-memory access with bounds check, req/ack handshake and timeout.
// Latency: non-memory or bad address -> out_valid 1 cycle after accept; memory op -> 1 + ack cycle.
// Backpressure: in_ready high only in IDLE; output pulse has no backpressure.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready            instruction handshake from the stage
//   icode, valE, valA, valP        instruction fields
//   mem_req/mem_we/mem_addr/mem_wdata   request to data memory, held until ack
//   mem_ack / mem_rdata            completion and read data from memory
//   out_valid, valM, stat          one-cycle completion pulse, read result, Y86 status
module mem_access_unit
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 4096,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] valE,
    input  logic [ADDR_W-1:0] valA,
    input  logic [ADDR_W-1:0] valP,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] valM,
    output logic [2:0]        stat
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value in the last REQ cycle we are willing to wait
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mau_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic              in_ready_nxt;
    logic              mem_req_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              out_valid_nxt;
    logic [DATA_W-1:0] valM_nxt;
    logic [2:0]        stat_nxt;

    logic              dec_is_mem;
    logic              dec_is_write;
    logic [ADDR_W-1:0] dec_addr;
    logic [DATA_W-1:0] dec_wdata;
    logic              dec_addr_ok;

    mem_op_decode #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_decode (
        .icode    (icode),
        .valE     (valE),
        .valA     (valA),
        .valP     (valP),
        .is_mem   (dec_is_mem),
        .is_write (dec_is_write),
        .addr     (dec_addr),
        .wdata    (dec_wdata),
        .addr_ok  (dec_addr_ok)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MAU_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            out_valid <= 1'b0;
            valM      <= '0;
            stat      <= S_AOK;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            in_ready  <= in_ready_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            out_valid <= out_valid_nxt;
            valM      <= valM_nxt;
            stat      <= stat_nxt;
        end
    end

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here describe what the outputs show in the next cycle.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        in_ready_nxt  = in_ready;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        out_valid_nxt = 1'b0;
        valM_nxt      = valM;
        stat_nxt      = stat;

        case (state)
            MAU_IDLE: begin
                cnt_nxt = '0;
                if (in_valid) begin
                    in_ready_nxt = 1'b0;
                    if (dec_is_mem && dec_addr_ok) begin
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = dec_is_write;
                        mem_addr_nxt  = dec_addr;
                        mem_wdata_nxt = dec_wdata;
                        state_nxt     = MAU_REQ;
                    end else begin
                        // Nothing to access, or the access is out of range:
                        // complete straight away without touching memory.
                        out_valid_nxt = 1'b1;
                        valM_nxt      = '0;
                        stat_nxt      = dec_is_mem ? S_ADR : S_AOK;
                        state_nxt     = MAU_DONE;
                    end
                end
            end

            MAU_REQ: begin
                // Ack is checked before the timeout so an ack in the final
                // allowed cycle still completes normally.
                if (mem_ack) begin
                    mem_req_nxt   = 1'b0;
                    out_valid_nxt = 1'b1;
                    valM_nxt      = mem_we ? '0 : mem_rdata;
                    stat_nxt      = S_AOK;
                    cnt_nxt       = '0;
                    state_nxt     = MAU_DONE;
                end else if (cnt == CNT_LAST) begin
                    mem_req_nxt   = 1'b0;
                    out_valid_nxt = 1'b1;
                    valM_nxt      = '0;
                    stat_nxt      = S_ADR;
                    cnt_nxt       = '0;
                    state_nxt     = MAU_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            MAU_DONE: begin
                cnt_nxt      = '0;
                in_ready_nxt = 1'b1;
                state_nxt    = MAU_IDLE;
            end

            default: begin
                cnt_nxt      = '0;
                mem_req_nxt  = 1'b0;
                in_ready_nxt = 1'b1;
                state_nxt    = MAU_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: scoreboard bench for mem_access_unit with a behavioural variable-latency memory.
// Latency: checks completion edge against accept edge plus expected handshake cycles.
// Backpressure: stimulus waits on in_ready before presenting each instruction.
module tb_mem_access_unit;
    import y86_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = 4'h0;
    logic [63:0] valE = '0, valA = '0, valP = '0;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic        ack_resp = 1'b0;
    logic        ack_spur = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        out_valid;
    logic [63:0] valM;
    logic [2:0]  stat;

    assign mem_ack = ack_resp | ack_spur;

    mem_access_unit #(
        .ADDR_W    (64),
        .DATA_W    (64),
        .MEM_BYTES (4096),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .valE      (valE),
        .valA      (valA),
        .valP      (valP),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .valM      (valM),
        .stat      (stat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] valm;
        logic [2:0]  st;
        int          edg;
    } exp_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
        bit          noack;
        bit          chk_cnt;
    } req_t;

    exp_t expq[$];
    req_t reqq[$];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, required %h (edge %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic push_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [63:0] rdata, input int delay, input bit noack,
                            input bit chk_cnt);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.rdata = rdata;
        r.delay = delay; r.noack = noack; r.chk_cnt = chk_cnt;
        reqq.push_back(r);
    endtask

    // Present one instruction; k = cycles from accept edge to completion edge.
    task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, input bit has_exp, input logic [63:0] xvalm,
                         input logic [2:0] xstat, input int k);
        int   guard;
        exp_t x;
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL issue_wait: in_ready=%b, required 1 within 200 cycles", in_ready);
        end
        icode    = ic;
        valE     = e;
        valA     = a;
        valP     = p;
        in_valid = 1'b1;
        if (has_exp) begin
            x.valm = xvalm;
            x.st   = xstat;
            x.edg  = cyc + 1 + k;
            expq.push_back(x);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Completion monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out_valid: out_valid=1 at edge %0d, required 0", cyc);
                end else begin
                    x = expq.pop_front();
                    chk("valM", valM, x.valm);
                    chk("stat", 64'(stat), 64'(x.st));
                    chk("out_edge", 64'(cyc), 64'(x.edg));
                end
            end
        end
    end

    // Behavioural data memory
    initial begin
        req_t d;
        int   hi;
        bit   stable;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (reqq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_mem_req: mem_req=1 addr=%h, required no request", mem_addr);
                    hi = 0;
                    while (mem_req === 1'b1 && hi < 1000) begin
                        @(negedge clk);
                        hi++;
                    end
                end else begin
                    d = reqq.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(d.we));
                    chk("mem_addr", mem_addr, d.addr);
                    if (d.we) chk("mem_wdata", mem_wdata, d.wdata);
                    stable = 1'b1;
                    if (!d.noack) begin
                        for (int i = 0; i < d.delay; i++) begin
                            @(negedge clk);
                            if (mem_req !== 1'b1) break;
                            if (mem_addr !== d.addr || mem_we !== d.we) stable = 1'b0;
                        end
                        chk("req_held", 64'(mem_req), 64'd1);
                        chk("req_stable", 64'(stable), 64'd1);
                        if (mem_req === 1'b1) begin
                            ack_resp  = 1'b1;
                            mem_rdata = d.rdata;
                            @(negedge clk);
                            ack_resp  = 1'b0;
                            mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                            chk("req_drop_after_ack", 64'(mem_req), 64'd0);
                        end
                    end else begin
                        hi = 0;
                        while (mem_req === 1'b1 && hi < 1000) begin
                            if (mem_addr !== d.addr || mem_we !== d.we) stable = 1'b0;
                            @(negedge clk);
                            hi++;
                        end
                        if (d.chk_cnt) begin
                            chk("timeout_req_cycles", 64'(hi), 64'(TO));
                            chk("req_stable", 64'(stable), 64'd1);
                        end
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int guard;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_stat", 64'(stat), 64'd1);
        rst = 1'b0;

        // mrmovq, ack 3 cycles after req rises
        push_req(1'b0, 64'h100, 64'h0, 64'hDEADBEEF, 3, 1'b0, 1'b0);
        issue(I_MRMOVQ, 64'h100, 64'h0, 64'h0, 1'b1, 64'hDEADBEEF, S_AOK, 4);
        // rmmovq crossing the top of memory: ADR, valM cleared from previous read
        issue(I_RMMOVQ, 64'hFF9, 64'h1234, 64'h0, 1'b1, 64'h0, S_ADR, 0);
        // pushq and call with zero-wait memory
        push_req(1'b1, 64'h1F8, 64'h55, 64'h0, 0, 1'b0, 1'b0);
        issue(I_PUSHQ, 64'h1F8, 64'h55, 64'h99, 1'b1, 64'h0, S_AOK, 1);
        push_req(1'b1, 64'h1F0, 64'h40, 64'h0, 0, 1'b0, 1'b0);
        issue(I_CALL, 64'h1F0, 64'h77, 64'h40, 1'b1, 64'h0, S_AOK, 1);
        // popq uses valA as address
        push_req(1'b0, 64'h200, 64'h0, 64'h1122334455667788, 1, 1'b0, 1'b0);
        issue(I_POPQ, 64'h208, 64'h200, 64'h0, 1'b1, 64'h1122334455667788, S_AOK, 2);
        // memory never acks: timeout after TO cycles
        push_req(1'b0, 64'h300, 64'h0, 64'h0, 0, 1'b1, 1'b1);
        issue(I_MRMOVQ, 64'h300, 64'h0, 64'h0, 1'b1, 64'h0, S_ADR, TO);
        // ret reads at valA
        push_req(1'b0, 64'h1F0, 64'h0, 64'h40, 2, 1'b0, 1'b0);
        issue(I_RET, 64'h1F8, 64'h1F0, 64'h0, 1'b1, 64'h40, S_AOK, 3);
        // nop: no memory, AOK
        issue(4'h1, 64'h100, 64'h100, 64'h0, 1'b1, 64'h0, S_AOK, 0);
        // address wrap-around is illegal
        issue(I_RMMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 64'h0, 1'b1, 64'h0, S_ADR, 0);
        // last legal 8-byte slot
        push_req(1'b1, 64'hFF8, 64'hABCD, 64'h0, 1, 1'b0, 1'b0);
        issue(I_RMMOVQ, 64'hFF8, 64'hABCD, 64'h0, 1'b1, 64'h0, S_AOK, 2);
        // ack arriving in the timeout cycle wins
        push_req(1'b0, 64'h400, 64'h0, 64'hCAFE_F00D, TO - 1, 1'b0, 1'b0);
        issue(I_MRMOVQ, 64'h400, 64'h0, 64'h0, 1'b1, 64'hCAFE_F00D, S_AOK, TO);

        // reset during REQ aborts with no completion
        push_req(1'b0, 64'h500, 64'h0, 64'h0, 0, 1'b1, 1'b0);
        issue(I_MRMOVQ, 64'h500, 64'h0, 64'h0, 1'b0, 64'h0, S_AOK, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        ack_spur = 1'b1;
        @(negedge clk);
        ack_spur = 1'b0;
        chk("spur_mem_req", 64'(mem_req), 64'd0);
        chk("spur_in_ready", 64'(in_ready), 64'd1);
        chk("spur_out_valid", 64'(out_valid), 64'd0);
        issue(4'h1, 64'h0, 64'h0, 64'h0, 1'b1, 64'h0, S_AOK, 0);

        guard = 0;
        while ((expq.size() != 0 || reqq.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk("pending_completions", 64'(expq.size()), 64'd0);
        chk("pending_mem_reqs", 64'(reqq.size()), 64'd0);
        chk("final_valM_held", valM, 64'd0);
        chk("final_stat_held", 64'(stat), 64'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle data-memory access controller for the Y86-64 core; replaces purely combinational address selection in the memory stage.
- Decodes the memory operation from icode and selects address and write data.
- Bounds-checks the access and runs a req/ack handshake to a variable-latency data memory, with a timeout.
- Returns valM plus a Y86 status code to the stage controller.

Parameters:
- ADDR_W, 64, address width (valE/valA/valP and mem_addr)
- DATA_W, 64, data width; access size is DATA_W/8 bytes
- MEM_BYTES, 4096, size of the legal data address space in bytes
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  stage presents an instruction for the memory phase
- in_ready  out  1  unit can accept (high only in IDLE)
- icode  in  4  instruction code
- valE  in  ADDR_W  ALU result
- valA  in  ADDR_W  register A value / old %rsp
- valP  in  ADDR_W  next PC (return address for call)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory completed the request this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- out_valid  out  1  one-cycle completion pulse
- valM  out  DATA_W  read result
- stat  out  3  1 = AOK, 3 = ADR

Behaviour:
- Reset (sync, active-high) forces:
  - state = IDLE, in_ready = 1
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - out_valid = 0, valM = 0, stat = 1
  - timeout counter = 0
- Reset mid-operation aborts immediately: mem_req low after the reset edge, no out_valid pulse.
- Decode, combinational, evaluated on acceptance:
  - icode 4 (rmmovq): write, addr = valE, wdata = valA
  - icode A (pushq): write, addr = valE, wdata = valA
  - icode 8 (call): write, addr = valE, wdata = valP
  - icode 5 (mrmovq): read, addr = valE
  - icode 9 (ret), B (popq): read, addr = valA
  - all other icodes: no memory operation
- Bounds check: illegal if addr + DATA_W/8 > MEM_BYTES.
  - Computed in ADDR_W+1 bits so that address wrap-around is flagged illegal.
  - Not applied to non-memory icodes.
- States: IDLE, REQ, DONE; all outputs registered.
- IDLE:
  - Accept on in_valid && in_ready at edge T.
  - Memory op and legal: register mem_addr, mem_we, mem_wdata; mem_req = 1 from T+1; go to REQ.
  - Non-memory op: go to DONE with stat = 1, valM = 0.
  - Illegal address: go to DONE with stat = 3, valM = 0, no mem_req.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack is sampled high.
  - mem_ack may already be high in the first REQ cycle (zero-wait memory).
  - On ack: mem_req = 0 next cycle; read captures valM = mem_rdata, write sets valM = 0; stat = 1; go to DONE.
  - Counter increments each REQ cycle without ack.
  - If no ack after TIMEOUT cycles: drop mem_req, stat = 3, valM = 0, go to DONE.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- DONE:
  - out_valid = 1 for exactly one cycle; output has no backpressure.
  - valM and stat are valid with the pulse and held until the next completion.
  - Next state is IDLE; counter cleared.
- Latency:
  - Non-memory op or ADR: out_valid at T+1.
  - Memory op with ack in REQ cycle k (k >= 1, first REQ cycle = 1): out_valid at T+1+k.
  - Unit is busy until IDLE, at T+2 or later.
- mem_ack outside REQ is ignored.
- in_valid outside IDLE is ignored; the producer must hold it.

Decomposition:
- Shared package y86_pkg:
  - icode constants (I_RMMOVQ = 4, I_MRMOVQ = 5, I_CALL = 8, I_RET = 9, I_PUSHQ = A, I_POPQ = B)
  - stat codes (S_AOK = 1, S_HLT = 2, S_ADR = 3, S_INS = 4)
  - state enum for this block
- Sub-module mem_op_decode (combinational):
  - inputs: icode, valE, valA, valP
  - outputs: is_mem, is_write, addr, wdata, addr_ok
  - parametrised by ADDR_W, DATA_W, MEM_BYTES

Test Plan:
- Reset, then mrmovq (icode 5), valE = 0x100, memory acks 3 cycles after mem_req rises with rdata = 0xDEADBEEF -> mem_addr = 0x100, mem_we = 0, out_valid one cycle after ack, valM = 0xDEADBEEF, stat = 1.
- pushq (icode A), valE = 0x1F8, valA = 0x55; call (icode 8), valE = 0x1F0, valP = 0x40; zero-wait ack -> mem_we = 1 with wdata 0x55, then 0x40; out_valid at T+2 each time; stat = 1.
- popq (icode B), valA = 0x200, valE = 0x208 -> mem_addr = 0x200, proving the valA path.
- rmmovq valE = 0xFF9 (MEM_BYTES = 4096) and valE = 0xFFFFFFFFFFFFFFFC -> no mem_req, out_valid at T+1, stat = 3.
- mrmovq with memory never acking, TIMEOUT = 8 -> mem_req high 8 cycles then low, stat = 3, valM = 0.
- Assert rst during REQ, with a spurious mem_ack sent while IDLE -> mem_req = 0 and in_ready = 1 after the edge, no out_valid; nop (icode 1) then completes at T+1 with stat = 1.
